mac_seq_ctrl: RTL

Sequencer and accumulator controller for the 8x8 unsigned multiplier datapath in tt_um_MAC_*. It takes a programmed count of operand pairs over a valid/ready stream and drives the external combinational multiplier inputs. Each returned product is added into a wide accumulator, and the final sum is presented on a result handshake. The block sits between the pin-level I/O adapter and the multiplier, and turns the bare multiply into a full dot-product MAC.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_acc_unit.sv | 40 ++++
 rtl/mac_seq_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC sequencer: state encoding, default widths,
// and the pair-count mapping where a programmed length of 0 means 2^CNT_W pairs.
package mac_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 20;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int unsigned terminal_count(input int unsigned len,
                                                 input int unsigned cnt_w);
    return (len == 0) ? (32'd1 << cnt_w) : len;
  endfunction

endpackage

// File: rtl/mac_acc_unit.sv
// Accumulator register with sticky overflow flag.
// Build option MAC_SAT_EN: clamp to all-ones on carry-out instead of wrapping.
module mac_acc_unit #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic [ACC_W:0] sum;
  logic           carry;

  // One spare bit on top of the accumulator captures the carry-out of each add.
  assign sum   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
  assign carry = sum[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
`ifdef MAC_SAT_EN
      acc <= carry ? '1 : sum[ACC_W-1:0];
`else
      acc <= sum[ACC_W-1:0];
`endif
      ovf <= ovf | carry;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product MAC sequencer: streams cfg_len operand pairs into an external multiplier
// and accumulates the products. Build option MAC_SAT_EN selects saturating accumulation.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_len,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [2*DATA_W-1:0] mul_p,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ACC_W-1:0]    res_data,
  output logic                res_ovf,
  output logic                done
);

  state_t         state;
  logic [CNT_W:0] remaining;
  logic           pend;
  logic           accept;
  logic           job_start;
  logic [ACC_W-1:0] acc;
  logic           ovf;

  assign busy      = (state != IDLE);
  // clear masks the handshakes in the same cycle so nothing is accepted or completed
  // while the abort is taking effect.
  assign in_ready  = (state == RUN) && (remaining != '0) && !clear;
  assign res_valid = (state == HOLD) && !clear;
  assign done      = res_valid && res_ready;
  assign accept    = in_valid && in_ready;
  assign job_start = (state == IDLE) && start && !clear;
  assign res_data  = acc;
  assign res_ovf   = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      pend      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else if (clear) begin
      state     <= IDLE;
      remaining <= '0;
      pend      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      pend <= accept;
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= (CNT_W + 1)'(terminal_count(32'(cfg_len), CNT_W));
            state     <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            remaining <= remaining - (CNT_W + 1)'(1);
            if (remaining == (CNT_W + 1)'(1))
              state <= DRAIN;
          end
        end
        DRAIN: state <= HOLD;
        HOLD: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mac_acc_unit #(
    .PROD_W (2 * DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (clear || job_start),
    .add_en (pend),
    .addend (mul_p),
    .acc    (acc),
    .ovf    (ovf)
  );

endmodule
